// File: rtl/move_controller_pkg.sv
// Shared Othello definitions: cell encoding, direction delta table, FSM states
// and the board-address helper used by move_controller and board_stepper.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_T_WAIT  = 4'd1,
        S_D_INIT  = 4'd2,
        S_D_EVAL  = 4'd3,
        S_F_WRITE = 4'd4,
        S_D_NEXT  = 4'd5,
        S_P_WRITE = 4'd6,
        S_ACK     = 4'd7,
        S_REJ     = 4'd8
    } state_t;

    // Direction order N, NE, E, SE, S, SW, W, NW; y grows downwards.
    function automatic logic signed [1:0] delta_x(input logic [2:0] dir);
        case (dir)
            3'd0:    delta_x = 2'sb00;
            3'd1:    delta_x = 2'sb01;
            3'd2:    delta_x = 2'sb01;
            3'd3:    delta_x = 2'sb01;
            3'd4:    delta_x = 2'sb00;
            3'd5:    delta_x = 2'sb11;
            3'd6:    delta_x = 2'sb11;
            3'd7:    delta_x = 2'sb11;
            default: delta_x = 2'sb00;
        endcase
    endfunction

    function automatic logic signed [1:0] delta_y(input logic [2:0] dir);
        case (dir)
            3'd0:    delta_y = 2'sb11;
            3'd1:    delta_y = 2'sb11;
            3'd2:    delta_y = 2'sb00;
            3'd3:    delta_y = 2'sb01;
            3'd4:    delta_y = 2'sb01;
            3'd5:    delta_y = 2'sb01;
            3'd6:    delta_y = 2'sb00;
            3'd7:    delta_y = 2'sb11;
            default: delta_y = 2'sb00;
        endcase
    endfunction

    function automatic logic [15:0] board_addr(input int unsigned log2,
                                               input logic [7:0] x,
                                               input logic [7:0] y);
        board_addr = ({8'd0, y} << log2) | {8'd0, x};
    endfunction

endpackage

// File: rtl/move_controller_board_stepper.sv
// Combinational one-cell step along a direction, forward or backward, with
// off-board detection on signed coordinates (no row wrap) and cell address.
module board_stepper
    import othello_pkg::*;
#(
    parameter int BOARD_LOG2 = 3
) (
    input  logic [BOARD_LOG2-1:0]   x,
    input  logic [BOARD_LOG2-1:0]   y,
    input  logic [2:0]              dir,
    input  logic                    back,
    output logic [BOARD_LOG2-1:0]   nx,
    output logic [BOARD_LOG2-1:0]   ny,
    output logic                    off_board,
    output logic [2*BOARD_LOG2-1:0] addr
);

    localparam int CW = BOARD_LOG2 + 1;

    logic signed [1:0]    dx2;
    logic signed [1:0]    dy2;
    logic signed [CW-1:0] dx;
    logic signed [CW-1:0] dy;
    logic signed [CW-1:0] rx;
    logic signed [CW-1:0] ry;

    // Signed step; the extra MSB flags both -1 and 2^BOARD_LOG2 as off-board.
    always_comb begin
        dx2       = delta_x(dir);
        dy2       = delta_y(dir);
        dx        = {{(CW-2){dx2[1]}}, dx2};
        dy        = {{(CW-2){dy2[1]}}, dy2};
        rx        = back ? (signed'({1'b0, x}) - dx) : (signed'({1'b0, x}) + dx);
        ry        = back ? (signed'({1'b0, y}) - dy) : (signed'({1'b0, y}) + dy);
        off_board = rx[CW-1] | ry[CW-1];
        nx        = rx[BOARD_LOG2-1:0];
        ny        = ry[BOARD_LOG2-1:0];
        addr      = (2*BOARD_LOG2)'(board_addr(BOARD_LOG2, 8'(nx), 8'(ny)));
    end

endmodule

// File: rtl/move_controller.sv
// Othello move responder: legality scan over 8 directions, flip walk-back and
// stone placement. Optional pass input is enabled by defining OTHELLO_PASS_EN.
module move_controller
    import othello_pkg::*;
#(
    parameter int BOARD_LOG2 = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    new_move,
    input  logic                    player,
    input  logic [BOARD_LOG2-1:0]   cur_x,
    input  logic [BOARD_LOG2-1:0]   cur_y,
    input  logic                    place,
`ifdef OTHELLO_PASS_EN
    input  logic                    pass,
`endif
    output logic [2*BOARD_LOG2-1:0] mem_addr,
    input  logic [1:0]              mem_rdata,
    output logic [1:0]              mem_wdata,
    output logic                    mem_we,
    output logic                    busy,
    output logic                    ack,
    output logic                    bad_move,
    output logic [5:0]              flip_count
);

    localparam int AW = 2 * BOARD_LOG2;

    state_t                state;
    logic [BOARD_LOG2-1:0] tx;
    logic [BOARD_LOG2-1:0] ty;
    logic                  me;
    logic [2:0]            dir;
    logic                  any;
    logic [BOARD_LOG2-1:0] run;
    logic [BOARD_LOG2-1:0] pos_x;
    logic [BOARD_LOG2-1:0] pos_y;
    logic [5:0]            flips;

    logic [1:0]            own;
    logic [1:0]            opp;
    logic [BOARD_LOG2-1:0] base_x;
    logic [BOARD_LOG2-1:0] base_y;
    logic                  step_back;
    logic [BOARD_LOG2-1:0] step_x;
    logic [BOARD_LOG2-1:0] step_y;
    logic                  step_off;
    logic [AW-1:0]         step_addr;
    logic [AW-1:0]         cur_addr;
    logic [AW-1:0]         t_addr;

    // Colour decode and stepper input selection (step back on own-stone hit and while flipping).
    always_comb begin
        own       = me ? CELL_WHITE : CELL_BLACK;
        opp       = me ? CELL_BLACK : CELL_WHITE;
        base_x    = (state == S_D_INIT) ? tx : pos_x;
        base_y    = (state == S_D_INIT) ? ty : pos_y;
        step_back = (state == S_F_WRITE) || ((state == S_D_EVAL) && (mem_rdata == own));
        cur_addr  = AW'(board_addr(BOARD_LOG2, 8'(cur_x), 8'(cur_y)));
        t_addr    = AW'(board_addr(BOARD_LOG2, 8'(tx), 8'(ty)));
    end

    board_stepper #(.BOARD_LOG2(BOARD_LOG2)) u_stepper (
        .x         (base_x),
        .y         (base_y),
        .dir       (dir),
        .back      (step_back),
        .nx        (step_x),
        .ny        (step_y),
        .off_board (step_off),
        .addr      (step_addr)
    );

    // Move FSM; all outputs are registered and set together with the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            tx         <= '0;
            ty         <= '0;
            me         <= 1'b0;
            dir        <= 3'd0;
            any        <= 1'b0;
            run        <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            flips      <= 6'd0;
            mem_addr   <= '0;
            mem_wdata  <= 2'b00;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            ack        <= 1'b0;
            bad_move   <= 1'b0;
            flip_count <= 6'd0;
        end else begin
            ack      <= 1'b0;
            bad_move <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (place && new_move) begin
                        tx       <= cur_x;
                        ty       <= cur_y;
                        me       <= player;
                        mem_addr <= cur_addr;
                        busy     <= 1'b1;
                        state    <= S_T_WAIT;
`ifdef OTHELLO_PASS_EN
                    end else if (pass && new_move) begin
                        flip_count <= 6'd0;
                        ack        <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ACK;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_T_WAIT: begin
                    if ((mem_rdata == CELL_BLACK) || (mem_rdata == CELL_WHITE)) begin
                        bad_move <= 1'b1;
                        state    <= S_REJ;
                    end else begin
                        dir   <= 3'd0;
                        any   <= 1'b0;
                        flips <= 6'd0;
                        state <= S_D_INIT;
                    end
                end
                S_D_INIT: begin
                    if (step_off) begin
                        state <= S_D_NEXT;
                    end else begin
                        mem_addr <= step_addr;
                        pos_x    <= step_x;
                        pos_y    <= step_y;
                        run      <= '0;
                        state    <= S_D_EVAL;
                    end
                end
                S_D_EVAL: begin
                    if (mem_rdata == opp) begin
                        run <= run + BOARD_LOG2'(1);
                        if (step_off) begin
                            state <= S_D_NEXT;
                        end else begin
                            mem_addr <= step_addr;
                            pos_x    <= step_x;
                            pos_y    <= step_y;
                        end
                    end else if ((mem_rdata == own) && (run != '0)) begin
                        // Bracketed run found: first write is the cell just before our stone.
                        mem_addr  <= step_addr;
                        pos_x     <= step_x;
                        pos_y     <= step_y;
                        mem_wdata <= own;
                        mem_we    <= 1'b1;
                        state     <= S_F_WRITE;
                    end else begin
                        state <= S_D_NEXT;
                    end
                end
                S_F_WRITE: begin
                    flips <= flips + 6'd1;
                    run   <= run - BOARD_LOG2'(1);
                    if (run == BOARD_LOG2'(1)) begin
                        mem_we <= 1'b0;
                        any    <= 1'b1;
                        state  <= S_D_NEXT;
                    end else begin
                        mem_addr <= step_addr;
                        pos_x    <= step_x;
                        pos_y    <= step_y;
                    end
                end
                S_D_NEXT: begin
                    if (dir == 3'd7) begin
                        if (any) begin
                            mem_addr  <= t_addr;
                            mem_wdata <= own;
                            mem_we    <= 1'b1;
                            state     <= S_P_WRITE;
                        end else begin
                            bad_move <= 1'b1;
                            state    <= S_REJ;
                        end
                    end else begin
                        dir   <= dir + 3'd1;
                        state <= S_D_INIT;
                    end
                end
                S_P_WRITE: begin
                    mem_we     <= 1'b0;
                    flip_count <= flips;
                    ack        <= 1'b1;
                    state      <= S_ACK;
                end
                S_ACK: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_REJ: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with an 8x8 board memory model and a write log.
module tb_move_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       new_move = 1'b0;
    logic       player = 1'b0;
    logic       place = 1'b0;
    logic [2:0] cur_x = 3'd0;
    logic [2:0] cur_y = 3'd0;
`ifdef OTHELLO_PASS_EN
    logic       pass = 1'b0;
`endif
    logic [5:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [1:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       ack;
    logic       bad_move;
    logic [5:0] flip_count;

    logic [1:0] mem [64];
    logic [1:0] init_board [64];
    logic       load = 1'b0;
    int         wcount = 0;
    logic [5:0] wlog_addr [256];
    logic [1:0] wlog_data [256];
    logic       watch24 = 1'b0;
    logic       saw24 = 1'b0;

    int checks = 0;
    int errors = 0;

    move_controller #(.BOARD_LOG2(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .new_move   (new_move),
        .player     (player),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .place      (place),
`ifdef OTHELLO_PASS_EN
        .pass       (pass),
`endif
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .busy       (busy),
        .ack        (ack),
        .bad_move   (bad_move),
        .flip_count (flip_count)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (load) mem <= init_board;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_we) begin
            wlog_addr[wcount[7:0]] <= mem_addr;
            wlog_data[wcount[7:0]] <= mem_wdata;
            wcount <= wcount + 1;
        end
        if (!watch24) saw24 <= 1'b0;
        else if (mem_addr == 6'd24) saw24 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) init_board[i] = 2'b00;
    endtask

    task automatic set_cell(input int x, input int y, input logic [1:0] v);
        init_board[y*8 + x] = v;
    endtask

    task automatic load_board();
        @(negedge clock); load = 1'b1;
        @(negedge clock); load = 1'b0;
    endtask

    task automatic opening_board();
        clear_board();
        set_cell(3, 3, 2'b10); set_cell(4, 4, 2'b10);
        set_cell(3, 4, 2'b01); set_cell(4, 3, 2'b01);
        load_board();
    endtask

    // lat counts negedges after the place edge: 1 = first cycle out of IDLE.
    task automatic do_place(input int x, input int y, input logic p,
                            output int lat, output logic got_ack, output logic got_bad);
        @(negedge clock);
        cur_x = 3'(x); cur_y = 3'(y); player = p; new_move = 1'b1; place = 1'b1;
        @(negedge clock);
        place = 1'b0;
        lat = 1;
        while (!ack && !bad_move && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        got_ack = ack;
        got_bad = bad_move;
    endtask

    initial begin
        int lat;
        int base;
        logic ga, gb, seen, found;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_bad", 32'(bad_move), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_flips", 32'(flip_count), 32'd0);
        reset = 1'b1;

        // Opening: black (3,2) flips (3,3)
        opening_board();
        base = wcount;
        do_place(3, 2, 1'b0, lat, ga, gb);
        check("open_ack", 32'(ga), 32'd1);
        check("open_bad", 32'(gb), 32'd0);
        check("open_flips", 32'(flip_count), 32'd1);
        check("open_wcount", 32'(wcount - base), 32'd2);
        check("open_w0_addr", 32'(wlog_addr[base[7:0]]), 32'd27);
        check("open_w0_data", 32'(wlog_data[base[7:0]]), 32'd1);
        check("open_w1_addr", 32'(wlog_addr[8'(base + 1)]), 32'd19);
        check("open_w1_data", 32'(wlog_data[8'(base + 1)]), 32'd1);
        check("open_lat_bound", 32'(lat <= 124), 32'd1);
        @(negedge clock);
        check("open_ack_pulse", 32'(ack), 32'd0);
        check("open_idle_busy", 32'(busy), 32'd0);

        // Occupied target
        opening_board();
        base = wcount;
        do_place(3, 3, 1'b0, lat, ga, gb);
        check("occ_bad", 32'(gb), 32'd1);
        check("occ_ack", 32'(ga), 32'd0);
        check("occ_lat", 32'(lat), 32'd2);
        check("occ_wcount", 32'(wcount - base), 32'd0);
        check("occ_cell", 32'(mem[27]), 32'd2);

        // Corner (0,0): no bracket anywhere, full 8-direction scan
        opening_board();
        base = wcount;
        do_place(0, 0, 1'b0, lat, ga, gb);
        check("corner_bad", 32'(gb), 32'd1);
        check("corner_lat", 32'(lat), 32'd21);
        check("corner_wcount", 32'(wcount - base), 32'd0);
        check("corner_cell", 32'(mem[0]), 32'd0);

        // White (4,2) flips (4,3)
        opening_board();
        base = wcount;
        do_place(4, 2, 1'b1, lat, ga, gb);
        check("white_ack", 32'(ga), 32'd1);
        check("white_flips", 32'(flip_count), 32'd1);
        check("white_flip_cell", 32'(mem[28]), 32'd2);
        check("white_place_cell", 32'(mem[20]), 32'd2);
        check("white_wcount", 32'(wcount - base), 32'd2);

        // Row wrap: E run runs off x=7, must not wrap onto (0,3)
        clear_board();
        set_cell(3, 2, 2'b01); set_cell(4, 2, 2'b10);
        set_cell(6, 2, 2'b10); set_cell(7, 2, 2'b10);
        set_cell(0, 3, 2'b01);
        load_board();
        base = wcount;
        watch24 = 1'b1;
        do_place(5, 2, 1'b0, lat, ga, gb);
        check("wrap_no_addr24", 32'(saw24), 32'd0);
        watch24 = 1'b0;
        check("wrap_ack", 32'(ga), 32'd1);
        check("wrap_flips", 32'(flip_count), 32'd1);
        check("wrap_e1", 32'(mem[22]), 32'd2);
        check("wrap_e2", 32'(mem[23]), 32'd2);
        check("wrap_w", 32'(mem[20]), 32'd1);
        check("wrap_target", 32'(mem[21]), 32'd1);
        check("wrap_wcount", 32'(wcount - base), 32'd2);

        // Multi-direction: 2-stone E run and 1-stone S run
        clear_board();
        set_cell(2, 1, 2'b10); set_cell(3, 1, 2'b10); set_cell(4, 1, 2'b01);
        set_cell(1, 2, 2'b10); set_cell(1, 3, 2'b01);
        load_board();
        base = wcount;
        do_place(1, 1, 1'b0, lat, ga, gb);
        check("multi_ack", 32'(ga), 32'd1);
        check("multi_flips", 32'(flip_count), 32'd3);
        check("multi_wcount", 32'(wcount - base), 32'd4);
        check("multi_w0", 32'(wlog_addr[base[7:0]]), 32'd11);
        check("multi_w1", 32'(wlog_addr[8'(base + 1)]), 32'd10);
        check("multi_w2", 32'(wlog_addr[8'(base + 2)]), 32'd17);
        check("multi_w3", 32'(wlog_addr[8'(base + 3)]), 32'd9);

        // place while new_move is low is ignored
        @(negedge clock);
        new_move = 1'b0; cur_x = 3'd3; cur_y = 3'd2; place = 1'b1;
        @(negedge clock);
        place = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || ack || bad_move || mem_we) seen = 1'b1;
            @(negedge clock);
        end
        check("nomove_quiet", 32'(seen), 32'd0);
        check("nomove_busy", 32'(busy), 32'd0);
        check("nomove_flips_held", 32'(flip_count), 32'd3);

        // Async reset during the flip walk-back
        clear_board();
        set_cell(2, 1, 2'b10); set_cell(3, 1, 2'b10); set_cell(4, 1, 2'b01);
        load_board();
        @(negedge clock);
        cur_x = 3'd1; cur_y = 3'd1; player = 1'b0; new_move = 1'b1; place = 1'b1;
        @(negedge clock);
        place = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_we) found = 1'b1;
            else @(negedge clock);
        end
        check("midflip_reached", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check("midflip_busy", 32'(busy), 32'd0);
        check("midflip_we", 32'(mem_we), 32'd0);
        check("midflip_ack", 32'(ack), 32'd0);
        check("midflip_flips", 32'(flip_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        opening_board();
        do_place(3, 2, 1'b0, lat, ga, gb);
        check("post_rst_ack", 32'(ga), 32'd1);
        check("post_rst_flips", 32'(flip_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
